// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB bus between NREQ single-word requesters.
// Runs APB SETUP/ACCESS with wait states and a timeout, then pulses gnt with the response.
module apb_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [2:0]         Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [31:0]        Paddr,
    output logic [31:0]        Pwdata,
    input  logic [31:0]        Prdata,
    input  logic               Pready,
    input  logic               Pslverr,
    output logic [1:0]         state_o
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   last_q;
    logic [7:0]      wait_q;
    logic [NREQ-1:0] gnt_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [2:0]      psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [31:0]     paddr_q;
    logic [31:0]     pwdata_q;

    logic [NREQ-1:0] eligible;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_write;
    logic [2:0]      sel_psel;

    // Masking with gnt_q keeps a requester that is still seeing its pulse from being re-granted.
    always_comb begin
        eligible   = req & ~gnt_q;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
                sel_write = req_write[i];
            end
        end
        case (sel_addr[31:24])
            8'h80:   sel_psel = 3'b001;
            8'h84:   sel_psel = 3'b010;
            8'h88:   sel_psel = 3'b100;
            default: sel_psel = 3'b000;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= IW'(NREQ - 1);
            wait_q    <= '0;
            gnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            gnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        idx_q <= pick_idx;
                        if (sel_psel != 3'b000) begin
                            state_q  <= S_SETUP;
                            psel_q   <= sel_psel;
                            paddr_q  <= sel_addr;
                            pwrite_q <= sel_write;
                            if (sel_write) begin
                                pwdata_q <= sel_wdata;
                            end
                        end else begin
                            state_q <= S_ERR;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // Timeout fires on the TIMEOUT-th ACCESS edge still lacking Pready.
                    if (Pready || (wait_q == 8'(TIMEOUT - 1))) begin
                        gnt_q     <= NREQ'(1) << idx_q;
                        err_q     <= Pready ? Pslverr : 1'b1;
                        rdata_q   <= (Pready && !Pslverr && !pwrite_q) ? Prdata : 32'h0;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        last_q    <= idx_q;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_ERR: begin
                    gnt_q   <= NREQ'(1) << idx_q;
                    err_q   <= 1'b1;
                    last_q  <= idx_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign Pselx     = psel_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed requests, an APB slave model, and a gnt scoreboard.
module tb_apb_req_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int EW      = 67;  // {gnt[1:0], rdata[31:0], err, cycle[31:0]}

    logic        Hclk;
    logic        Hresetn;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  gnt;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic [1:0]  dbg_state;

    int            cyc;
    int            checks;
    int            errors;
    int            slv_wait;
    logic          slv_hang;
    int            acc_n;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .state_o   (dbg_state)
    );

    // Clock and free-running edge counter
    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial cyc = 0;
    always @(posedge Hclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // APB slave: Pready after slv_wait low ACCESS cycles, never when slv_hang is set.
    initial begin
        Pready = 1'b0;
        acc_n  = 0;
    end
    always @(negedge Hclk) begin
        if (Pselx != 3'b000 && Penable) begin
            Pready = !slv_hang && (acc_n >= slv_wait);
            acc_n  = acc_n + 1;
        end else begin
            Pready = 1'b0;
            acc_n  = 0;
        end
    end

    // Monitor: every gnt pulse pops one expected response
    always @(negedge Hclk) begin
        if (Hresetn && gnt != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt actual=%b required=none", gnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("gnt", {62'd0, gnt}, {62'd0, mon_e[66:65]});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mon_e[64:33]});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e[32]});
                check("gnt_cycle", 64'(cyc), {32'd0, mon_e[31:0]});
            end
        end
    end

    // Single request from requester i; w = extra cycles beyond the 3-cycle minimum (-1 for ERR).
    task automatic do_req(input int i, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] epsel,
                          input logic [31:0] erdata, input logic eerr, input int w);
        logic [1:0] oh;
        logic       done;
        @(negedge Hclk);
        oh   = 2'b01 << i;
        done = 1'b0;
        req_write[i]         = wr;
        req_addr[32*i +: 32] = addr;
        req_wdata[32*i +: 32] = wdata;
        exp_q.push_back({oh, erdata, eerr, 32'(cyc + 3 + w)});
        req[i] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Hclk);
            if (gnt[i]) begin
                check("idle_psel_at_gnt", {61'd0, Pselx}, 64'd0);
                check("idle_penable_at_gnt", {63'd0, Penable}, 64'd0);
                done = 1'b1;
                break;
            end
            if (epsel == 3'b000) begin
                check("no_apb_psel", {61'd0, Pselx}, 64'd0);
                check("no_apb_penable", {63'd0, Penable}, 64'd0);
            end else begin
                check("psel", {61'd0, Pselx}, {61'd0, epsel});
                check("paddr", {32'd0, Paddr}, {32'd0, addr});
                check("pwrite", {63'd0, Pwrite}, {63'd0, wr});
                check("penable", {63'd0, Penable}, (k == 1) ? 64'd0 : 64'd1);
                if (wr) check("pwdata", {32'd0, Pwdata}, {32'd0, wdata});
            end
        end
        check("gnt_seen", {63'd0, done}, 64'd1);
        req[i] = 1'b0;
    endtask

    initial begin
        int c;
        int n;
        checks    = 0;
        errors    = 0;
        Hresetn   = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        Prdata    = '0;
        Pslverr   = 1'b0;
        slv_wait  = 0;
        slv_hang  = 1'b0;
        #1;
        check("rst_gnt", {62'd0, gnt}, 64'd0);
        check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("rst_err", {63'd0, rsp_err}, 64'd0);
        check("rst_psel", {61'd0, Pselx}, 64'd0);
        check("rst_penable", {63'd0, Penable}, 64'd0);
        check("rst_paddr", {32'd0, Paddr}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);
        repeat (2) @(negedge Hclk);
        Hresetn = 1'b1;

        // Single read, immediate Pready
        Prdata = 32'hDEAD_BEEF;
        do_req(0, 1'b0, 32'h8000_0010, 32'h0, 3'b001, 32'hDEAD_BEEF, 1'b0, 0);

        // Write with two wait states
        slv_wait = 2;
        do_req(1, 1'b1, 32'h8800_0004, 32'h1234_5678, 3'b100, 32'h0, 1'b0, 2);
        slv_wait = 0;

        // Both requesters held: 0,1,0,1 with one idle bus cycle between transfers
        @(negedge Hclk);
        Prdata          = 32'h0BAD_F00D;
        req_addr[31:0]  = 32'h8000_0020;
        req_write[0]    = 1'b0;
        req_addr[63:32] = 32'h8400_0030;
        req_wdata[63:32] = 32'hCAFE_0001;
        req_write[1]    = 1'b1;
        c = cyc;
        exp_q.push_back({2'b01, 32'h0BAD_F00D, 1'b0, 32'(c + 3)});
        exp_q.push_back({2'b10, 32'h0, 1'b0, 32'(c + 6)});
        exp_q.push_back({2'b01, 32'h0BAD_F00D, 1'b0, 32'(c + 9)});
        exp_q.push_back({2'b10, 32'h0, 1'b0, 32'(c + 12)});
        req = 2'b11;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Hclk);
            if (gnt != 2'b00) begin
                n++;
                check("rr_idle_psel", {61'd0, Pselx}, 64'd0);
                if (n == 3) req[0] = 1'b0;
                if (n == 4) begin
                    req[1] = 1'b0;
                    break;
                end
            end
        end
        check("rr_grant_count", 64'(n), 64'd4);

        // Undecodable address, then slave error on a valid one
        do_req(0, 1'b0, 32'h9000_0000, 32'h0, 3'b000, 32'h0, 1'b1, -1);
        Pslverr = 1'b1;
        Prdata  = 32'h1111_2222;
        do_req(1, 1'b0, 32'h8400_0008, 32'h0, 3'b010, 32'h0, 1'b1, 0);
        Pslverr = 1'b0;

        // Timeout, then a normal transfer
        slv_hang = 1'b1;
        do_req(0, 1'b0, 32'h8800_0100, 32'h0, 3'b100, 32'h0, 1'b1, TIMEOUT - 1);
        slv_hang = 1'b0;
        Prdata = 32'h5555_AAAA;
        do_req(0, 1'b0, 32'h8000_0200, 32'h0, 3'b001, 32'h5555_AAAA, 1'b0, 0);

        // Reset during ACCESS: aborted transfer never grants, priority restarts at 0
        @(negedge Hclk);
        slv_hang        = 1'b1;
        req_addr[63:32] = 32'h8000_0040;
        req_write[1]    = 1'b0;
        req[1]          = 1'b1;
        repeat (3) @(negedge Hclk);
        check("pre_rst_access", {63'd0, Penable}, 64'd1);
        req_addr[31:0] = 32'h8400_0050;
        req_write[0]   = 1'b0;
        req[0]         = 1'b1;
        #2 Hresetn = 1'b0;
        #1;
        check("arst_gnt", {62'd0, gnt}, 64'd0);
        check("arst_psel", {61'd0, Pselx}, 64'd0);
        check("arst_penable", {63'd0, Penable}, 64'd0);
        check("arst_paddr", {32'd0, Paddr}, 64'd0);
        check("arst_pwdata", {32'd0, Pwdata}, 64'd0);
        check("arst_state", {62'd0, dbg_state}, 64'd0);
        @(negedge Hclk);
        check("rst_hold_gnt", {62'd0, gnt}, 64'd0);
        slv_hang = 1'b0;
        Prdata   = 32'h7777_0000;
        Hresetn  = 1'b1;
        c = cyc;
        exp_q.push_back({2'b01, 32'h7777_0000, 1'b0, 32'(c + 3)});
        exp_q.push_back({2'b10, 32'h7777_0000, 1'b0, 32'(c + 6)});
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Hclk);
            if (k == 1) check("restart_setup_psel", {61'd0, Pselx}, 64'd2);
            if (gnt[0]) req[0] = 1'b0;
            if (gnt[1]) begin
                req[1] = 1'b0;
                n = 1;
                break;
            end
        end
        check("restart_done", 64'(n), 64'd1);

        repeat (3) @(negedge Hclk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
